// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with configurable modulus, wrap/saturate mode,
// synchronous clear/load, a terminal-count flag and a registered wrap pulse.
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic             at_max, at_min;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);
  assign tc     = en & ((up & at_max) | (~up & at_min));

  // Boundaries are handled by compare-and-reload, so non-power-of-2 moduli
  // never depend on natural WIDTH-bit overflow.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (ld) begin
      q_nxt = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          q_nxt = q + ONE_Q;
        end else if (!SATURATE) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_nxt = q - ONE_Q;
        end else if (!SATURATE) begin
          q_nxt    = MAX_Q;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter; the next generation of the team's fixed 4-bit enable-only synchronous counter. It adds the following over that counter:
- configurable width and modulus;
- direction control;
- synchronous clear and parallel load;
- wrap or saturate mode;
- a terminal-count flag and a registered wrap pulse for cascading.

It is used as a building block for dividers, timers and cascaded multi-digit counters.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1, >=1)
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear to 0
ld  input  1  synchronous parallel load of d
d  input  WIDTH  load value
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
q  output  WIDTH  current count (registered)
tc  output  1  terminal count flag (combinational)
wrap  output  1  one-cycle pulse, registered, marks that a wrap occurred on the previous edge

Behaviour:
- Reset: rst=0 forces q=0 and wrap=0 immediately, independent of clk. On release, counting resumes at the first rising edge where rst=1.
- Priority at each rising edge, highest first: clr > ld > en > hold.
- clr=1: q<=0, wrap<=0.
- ld=1 (clr=0): q<=d if d<=MAX_VAL, else q<=MAX_VAL (clamp); wrap<=0.
- en=1, up=1, q<MAX_VAL: q<=q+1; wrap<=0.
- en=1, up=1, q==MAX_VAL:
  - SATURATE=0: q<=0, wrap<=1.
  - SATURATE=1: q holds, wrap<=0.
- en=1, up=0, q>0: q<=q-1; wrap<=0.
- en=1, up=0, q==0:
  - SATURATE=0: q<=MAX_VAL, wrap<=1.
  - SATURATE=1: q holds, wrap<=0.
- en=0 (clr=0, ld=0): q holds, wrap<=0.
- tc = en & ((up & q==MAX_VAL) | (~up & q==0)). It is purely combinational and is high in both modes; it is intended as the next stage's en when cascading.
- wrap is high for exactly one cycle after each wrapping edge. Back-to-back wraps (e.g. MAX_VAL=1 counting continuously) keep wrap high on consecutive cycles.
- Direction change takes effect on the same edge; there is no pipeline latency. q changes one cycle after the enabling inputs are sampled.
- All arithmetic is WIDTH bits and never relies on natural overflow. Wrap is explicit compare-and-reload, so non-power-of-2 MAX_VAL works in both directions.
- Reset mid-count: q and wrap clear asynchronously, and any pending load or count is discarded.
- Inputs are sampled only on rising edges. Glitches between edges do not alter q; they can only alter tc.

Test Plan:
1. WIDTH=4, MAX_VAL=15, SATURATE=0; rst low 7.5 ns then high; en=1, up=1 for 20 cycles -> q counts 0..15, then 0..3. tc=1 while q=15. wrap=1 for exactly one cycle, when q=0 after the wrap.
2. WIDTH=4, MAX_VAL=9 (decade), SATURATE=0, up=0 from q=0 -> sequence 9,8,...,0,9. wrap pulses after 0->9. Then ld=1, d=12 -> q=9 (clamped).
3. SATURATE=1, MAX_VAL=9, up=1 for 12 cycles -> q stops at 9 and holds; tc stays 1, wrap never asserts. Then up=0 -> q decrements to 0 and holds; tc=1 at 0.
4. Priority: assert clr=1, ld=1, d=5, en=1 together -> q=0. Next cycle clr=0, ld=1, en=1 -> q=5 (load beats count). Then en=0 for 3 cycles -> q stays 5.
5. Asynchronous reset mid-operation: q=7 counting up; drive rst=0 between clock edges -> q=0 and wrap=0 immediately, before the next edge. q stays 0 while rst=0; counting restarts from 1 at the first edge after release.
6. Cascade: two instances (MAX_VAL=9), with the second stage's en tied to the first stage's tc -> after 37 enabled cycles {hi,lo} = 3,7; the hi digit steps exactly once per lo 9->0 transition.
